// File: rtl/router_trace_collector_pkg.sv
// rtl/router_trace_collector_pkg.sv - shared types and helpers for the router trace collector
// Contents: capture FSM state enum, default widths, entry width, saturating increment.
package trace_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } tc_state_e;

  localparam int TRACE_W = 32;
  localparam int TS_W    = 16;
  localparam int ENTRY_W = TS_W + TRACE_W;

  // Increment that sticks at the all-ones value of a width-bit counter.
  // Works on a 32-bit container; callers size-cast the result back down.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/router_trace_collector_if.sv
// rtl/router_trace_collector_if.sv - host read port of the trace collector
// Signals: out_valid (head entry present), out_data ({timestamp, trace}), out_ready (host accepts).
// master: collector side, drives valid/data. slave: host side, drives ready.
interface router_trace_collector_if
  import trace_collector_pkg::*;
#(
  parameter int DATA_W = ENTRY_W
) ();

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/router_trace_collector_fifo.sv
// rtl/router_trace_collector_fifo.sv - synchronous first-word-fall-through FIFO (module trace_fifo)
// Ports: clk, reset (sync, active-high), clr (pointer flush), wr_en/wr_data, rd_en/rd_data,
//        full, empty, count (stored entries).
module trace_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer bit distinguishes full from empty; the difference wraps naturally.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign do_rd = rd_en & ~empty;
  // A write into a full FIFO is safe only when the head leaves in the same cycle.
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/router_trace_collector.sv
// rtl/router_trace_collector.sv - timestamping capture sink for a router trigger/trace pair
// Ports: clk, reset (sync, active-high), arm/stop session pulses, trigger/trace from the router,
//        rd (read port, master), state (FSM), fill_level (stored entries), drop_cnt (saturating).
module router_trace_collector
  import trace_collector_pkg::*;
#(
  parameter int TRACEw = 32,
  parameter int TSw    = 16,
  parameter int DEPTH  = 16,
  parameter int DROPw  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trigger,
  input  logic [TRACEw-1:0]        trace,
  router_trace_collector_if.master rd,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [DROPw-1:0]         drop_cnt
);

  tc_state_e                 state_q;
  tc_state_e                 state_d;
  logic                      arm_accept;
  logic                      capture_window;
  logic [TSw-1:0]            ts_q;
  logic [TSw-1:0]            ts_now;
  logic                      wr_req;
  logic                      wr_accept;
  logic                      rd_fire;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [TSw+TRACEw-1:0]     fifo_dout;
  logic [DROPw-1:0]          drop_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. In ARMED, stop takes precedence over trigger; a word
  // sampled in that cycle is still stored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (stop)         state_d = ST_IDLE;
        else if (trigger) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: if (stop) state_d = ST_FROZEN;
      ST_FROZEN:  if ((fill_level == '0) && !wr_accept) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    arm_accept     = 1'b0;
    capture_window = 1'b0;
    case (state_q)
      ST_IDLE:    arm_accept     = arm;
      ST_ARMED:   capture_window = 1'b1;
      ST_CAPTURE: capture_window = 1'b1;
      default:    ;
    endcase
  end

  // The counter reads as zero in the arm cycle itself, so the first word
  // after arm carries timestamp 1.
  assign ts_now = arm_accept ? '0 : ts_q;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_now + TSw'(1);
  end

  assign rd_fire   = rd.out_valid & rd.out_ready;
  assign wr_req    = capture_window & trigger;
  assign wr_accept = wr_req & (~fifo_full | rd_fire);

  always_ff @(posedge clk) begin
    if (reset || arm_accept) drop_q <= '0;
    else if (wr_req && !wr_accept) drop_q <= DROPw'(sat_inc(32'(drop_q), DROPw));
  end

  trace_fifo #(
    .W     (TSw + TRACEw),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (arm_accept),
    .wr_en   (wr_accept),
    .wr_data ({ts_now, trace}),
    .rd_en   (rd_fire),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill_level)
  );

  assign rd.out_valid = ~fifo_empty;
  assign rd.out_data  = fifo_dout;
  assign state        = state_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_router_trace_collector.sv
// tb/tb_router_trace_collector.sv - scoreboard bench for router_trace_collector
module tb_router_trace_collector;
  import trace_collector_pkg::*;

  localparam int EW    = 48;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] trace = '0;
  logic [1:0]  state;
  logic [4:0]  fill_level;
  logic [15:0] drop_cnt;

  router_trace_collector_if #(.DATA_W(EW)) rd_if ();

  router_trace_collector #(
    .TRACEw (32),
    .TSw    (16),
    .DEPTH  (DEPTH),
    .DROPw  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .stop       (stop),
    .trigger    (trigger),
    .trace      (trace),
    .rd         (rd_if),
    .state      (state),
    .fill_level (fill_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [47:0] exp_q [$];
  int          m_state = 0;
  int          m_fill = 0;
  logic [15:0] m_ts = '0;
  logic [15:0] m_drop = '0;

  initial rd_if.out_ready = 1'b0;

  // Reference model: advances one clock and pushes every accepted word.
  task automatic step();
    bit          arm_acc, wr_req, rd, wacc;
    logic [15:0] ts_now;
    int          n_state;
    arm_acc = (m_state == 0) && arm;
    ts_now  = arm_acc ? 16'd0 : m_ts;
    wr_req  = ((m_state == 1) || (m_state == 2)) && trigger;
    rd      = (m_fill > 0) && rd_if.out_ready;
    wacc    = wr_req && ((m_fill < DEPTH) || rd);
    n_state = m_state;
    case (m_state)
      0: if (arm) n_state = 1;
      1: if (stop) n_state = 0; else if (trigger) n_state = 2;
      2: if (stop) n_state = 3;
      default: if (m_fill == 0) n_state = 0;
    endcase
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_fill = 0; m_ts = '0; m_drop = '0;
      exp_q.delete();
    end else begin
      if (wacc) exp_q.push_back({ts_now, trace});
      if (arm_acc) begin
        m_fill = 0; m_drop = '0;
        exp_q.delete();
      end else begin
        m_fill = m_fill + (wacc ? 1 : 0) - (rd ? 1 : 0);
        if (wr_req && !wacc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      m_state = n_state;
      m_ts    = ts_now + 16'd1;
    end
    #1;
  endtask

  // Output monitor: compares every completed read against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      vectors++;
      if (rd_if.out_valid !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL out_valid got %b want %b", rd_if.out_valid, exp_q.size() != 0);
      end
      if (rd_if.out_valid === 1'b1 && rd_if.out_ready === 1'b1 && exp_q.size() != 0) begin
        logic [47:0] exp_e;
        exp_e = exp_q.pop_front();
        vectors++;
        if (rd_if.out_data !== exp_e) begin
          miscompares++;
          $display("FAIL read_data got %h want %h", rd_if.out_data, exp_e);
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    rd_if.out_ready = 1'b1;
    trigger = 1'b0;
    while ((exp_q.size() != 0 || state !== 2'd0) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout got state %0d queue %0d want idle and empty", state, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++; if (rd_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", rd_if.out_valid); end
    vectors++; if (rd_if.out_data !== 48'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", rd_if.out_data); end
    vectors++; if (fill_level !== 5'd0) begin miscompares++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_basic();
    rd_if.out_ready = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL basic_armed got %0d want 1", state); end
    trigger = 1'b1; trace = 32'hA0; step();
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL basic_capture got %0d want 2", state); end
    vectors++; if (rd_if.out_data !== {16'd1, 32'hA0}) begin miscompares++; $display("FAIL basic_first got %h want %h", rd_if.out_data, {16'd1, 32'hA0}); end
    trace = 32'hA1; step();
    trace = 32'hA2; step();
    trigger = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL basic_frozen got %0d want 3", state); end
    step();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL basic_idle got %0d want 0", state); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_unread got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stop_drain();
    rd_if.out_ready = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 5; i++) begin trace = 32'h200 + i; step(); end
    trigger = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL stop_frozen got %0d want 3", state); end
    vectors++; if (fill_level !== 5'd5) begin miscompares++; $display("FAIL stop_fill got %0d want 5", fill_level); end
    trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin trace = 32'h2F0 + i; step(); end
    trigger = 1'b0;
    vectors++; if (fill_level !== 5'd5) begin miscompares++; $display("FAIL stop_ignore got %0d want 5", fill_level); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL stop_drop got %0d want 0", drop_cnt); end
    rd_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fill_level === 5'd0) break;
    end
    vectors++; if (fill_level !== 5'd0) begin miscompares++; $display("FAIL stop_drained got %0d want 0", fill_level); end
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL stop_still_frozen got %0d want 3", state); end
    step();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL stop_to_idle got %0d want 0", state); end
  endtask

  task automatic test_overflow();
    rd_if.out_ready = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 20; i++) begin trace = 32'h100 + i; step(); end
    trigger = 1'b0;
    vectors++; if (fill_level !== 5'd16) begin miscompares++; $display("FAIL ovf_fill got %0d want 16", fill_level); end
    vectors++; if (drop_cnt !== 16'd4) begin miscompares++; $display("FAIL ovf_drop got %0d want 4", drop_cnt); end
    vectors++; if (rd_if.out_data !== {16'd1, 32'h100}) begin miscompares++; $display("FAIL ovf_head got %h want %h", rd_if.out_data, {16'd1, 32'h100}); end
    // Full FIFO, read and trigger in the same cycle.
    trigger = 1'b1; trace = 32'h1FF; rd_if.out_ready = 1'b1; step();
    trigger = 1'b0; rd_if.out_ready = 1'b0;
    vectors++; if (fill_level !== 5'd16) begin miscompares++; $display("FAIL full_rw_fill got %0d want 16", fill_level); end
    vectors++; if (drop_cnt !== 16'd4) begin miscompares++; $display("FAIL full_rw_drop got %0d want 4", drop_cnt); end
    stop = 1'b1; step(); stop = 1'b0;
    // arm is ignored outside IDLE; triggers are ignored while frozen.
    arm = 1'b1; trigger = 1'b1; step(); step(); arm = 1'b0; trigger = 1'b0;
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL ovf_arm_ignored got %0d want 3", state); end
    vectors++; if (fill_level !== 5'd16) begin miscompares++; $display("FAIL ovf_frozen_fill got %0d want 16", fill_level); end
    drain(64);
    vectors++; if (drop_cnt !== 16'd4) begin miscompares++; $display("FAIL ovf_drop_kept got %0d want 4", drop_cnt); end
  endtask

  task automatic test_rearm();
    rd_if.out_ready = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL rearm_drop got %0d want 0", drop_cnt); end
    // stop together with trigger while armed: word stored, session closes.
    trigger = 1'b1; stop = 1'b1; trace = 32'hBB; step();
    trigger = 1'b0; stop = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rearm_stop got %0d want 0", state); end
    vectors++; if (fill_level !== 5'd1) begin miscompares++; $display("FAIL rearm_left got %0d want 1", fill_level); end
    step(); step(); step();
    arm = 1'b1; step(); arm = 1'b0;
    vectors++; if (fill_level !== 5'd0) begin miscompares++; $display("FAIL rearm_flush got %0d want 0", fill_level); end
    vectors++; if (rd_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL rearm_valid got %b want 0", rd_if.out_valid); end
    trigger = 1'b1; trace = 32'hCC; step(); trigger = 1'b0;
    vectors++; if (rd_if.out_data !== {16'd1, 32'hCC}) begin miscompares++; $display("FAIL rearm_first got %h want %h", rd_if.out_data, {16'd1, 32'hCC}); end
    stop = 1'b1; step(); stop = 1'b0;
    drain(16);
  endtask

  task automatic test_reset_mid();
    rd_if.out_ready = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 7; i++) begin trace = 32'h300 + i; step(); end
    trigger = 1'b0;
    vectors++; if (fill_level !== 5'd7) begin miscompares++; $display("FAIL mid_fill got %0d want 7", fill_level); end
    reset = 1'b1; step(); reset = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL mid_state got %0d want 0", state); end
    vectors++; if (rd_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", rd_if.out_valid); end
    vectors++; if (rd_if.out_data !== 48'h0) begin miscompares++; $display("FAIL mid_data got %h want 0", rd_if.out_data); end
    vectors++; if (fill_level !== 5'd0) begin miscompares++; $display("FAIL mid_fill0 got %0d want 0", fill_level); end
    // arm and stop together in IDLE: arm wins.
    arm = 1'b1; stop = 1'b1; step(); arm = 1'b0; stop = 1'b0;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL mid_arm_wins got %0d want 1", state); end
    trigger = 1'b1; trace = 32'hD0; step(); trigger = 1'b0;
    vectors++; if (rd_if.out_data !== {16'd1, 32'hD0}) begin miscompares++; $display("FAIL mid_first got %h want %h", rd_if.out_data, {16'd1, 32'hD0}); end
    stop = 1'b1; step(); stop = 1'b0;
    drain(16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_drain();
    test_overflow();
    test_rearm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
